// File: rtl/regfile_access_ctrl_if.sv
// Command/response and register-file port bundle for regfile_access_ctrl.
// master = command issuer plus register-file storage, slave = the controller.
interface regfile_access_ctrl_if #(
  parameter int REG_WIDTH   = 32,
  parameter int RADDR_WIDTH = 5
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; the offering side holds valid and payload stable until then.
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [RADDR_WIDTH-1:0] cmd_addr;
  logic [REG_WIDTH-1:0]   cmd_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [RADDR_WIDTH-1:0] rsp_addr;
  logic [REG_WIDTH-1:0]   rsp_data;
  logic                   rsp_last;
  logic                   rf_we;
  logic [RADDR_WIDTH-1:0] rf_rd_addr;
  logic [REG_WIDTH-1:0]   rf_rd_value;
  logic [RADDR_WIDTH-1:0] rf_rs1_addr;
  logic [REG_WIDTH-1:0]   rf_rs1_value;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, rf_rs1_value,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last,
           rf_we, rf_rd_addr, rf_rd_value, rf_rs1_addr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, rf_rs1_value,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last,
           rf_we, rf_rd_addr, rf_rd_value, rf_rs1_addr
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: single read/write, dump-all and clear-all
// commands issued over a valid/ready command channel, answered on a response channel.
module regfile_access_ctrl #(
  parameter int REG_DEPTH   = 32,
  parameter int REG_WIDTH   = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_access_ctrl_if.slave bus,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_CLEAR = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [RADDR_WIDTH-1:0] LAST_ADDR = RADDR_WIDTH'(REG_DEPTH - 1);

  state_t                 state, state_nx;
  logic [1:0]             op_q;
  logic [RADDR_WIDTH-1:0] cur_addr;
  logic [REG_WIDTH-1:0]   wdata_q;
  logic [RADDR_WIDTH-1:0] rsp_addr_q;
  logic [REG_WIDTH-1:0]   rsp_data_q;
  logic                   rsp_last_q;
  logic                   dump_more;

  // A dump continues while the response being handed over is not the last one.
  assign dump_more = (op_q == OP_DUMP) && !rsp_last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_WRITE: state_nx = S_WRITE;
            OP_CLEAR: state_nx = S_CLEAR;
            default:  state_nx = S_READ;
          endcase
        end
      end
      S_READ:  state_nx = S_RESP;
      S_WRITE: state_nx = S_RESP;
      S_CLEAR: if (cur_addr == LAST_ADDR) state_nx = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nx = dump_more ? S_READ : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // cur_addr is the target register for read/write and the walk counter for dump/clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= OP_READ;
      cur_addr   <= '0;
      wdata_q    <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q    <= bus.cmd_op;
            wdata_q <= bus.cmd_wdata;
            case (bus.cmd_op)
              OP_DUMP:  cur_addr <= '0;
              OP_CLEAR: cur_addr <= RADDR_WIDTH'(1);
              default:  cur_addr <= bus.cmd_addr;
            endcase
          end
        end
        S_READ: begin
          rsp_addr_q <= cur_addr;
          rsp_data_q <= bus.rf_rs1_value;
          rsp_last_q <= (op_q != OP_DUMP) || (cur_addr == LAST_ADDR);
        end
        S_WRITE: begin
          rsp_addr_q <= cur_addr;
          rsp_data_q <= (cur_addr == '0) ? '0 : wdata_q;
          rsp_last_q <= 1'b1;
        end
        S_CLEAR: begin
          if (cur_addr == LAST_ADDR) begin
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b1;
          end else begin
            cur_addr <= cur_addr + RADDR_WIDTH'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready && dump_more) cur_addr <= cur_addr + RADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.cmd_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rf_we       = 1'b0;
    bus.rf_rd_addr  = '0;
    bus.rf_rd_value = '0;
    bus.rf_rs1_addr = '0;
    busy            = 1'b1;
    case (state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b0;
      end
      S_READ: bus.rf_rs1_addr = cur_addr;
      S_WRITE: begin
        // Register 0 is read-only: the write is dropped, not forwarded.
        if (cur_addr != '0) begin
          bus.rf_we       = 1'b1;
          bus.rf_rd_addr  = cur_addr;
          bus.rf_rd_value = wdata_q;
        end
      end
      S_CLEAR: begin
        bus.rf_we      = 1'b1;
        bus.rf_rd_addr = cur_addr;
      end
      S_RESP: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.rsp_addr = rsp_addr_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_last = rsp_last_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: register-file storage model, write log,
// and a reference array of expected register contents.
module tb_regfile_access_ctrl;
  localparam int DEPTH = 32;
  localparam int W     = 32;
  localparam int AW    = 5;

  typedef struct packed {
    int          cyc;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          busy;
  logic [2:0]    state_dbg;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [W-1:0]  pre_data = '0;
  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  ref_mem [DEPTH];
  logic [W-1:0]  exp_q [$];
  wr_t           wr_q [$];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  regfile_access_ctrl_if #(.REG_WIDTH(W), .RADDR_WIDTH(AW)) bus ();

  regfile_access_ctrl #(.REG_DEPTH(DEPTH), .REG_WIDTH(W), .RADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign bus.rf_rs1_value = mem[bus.rf_rs1_addr];

  always @(posedge clk) begin
    if (pre_en)         mem[pre_addr] <= pre_data;
    else if (bus.rf_we) mem[bus.rf_rd_addr] <= bus.rf_rd_value;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.rf_we) wr_q.push_back('{cyc: cyc, a: bus.rf_rd_addr, d: bus.rf_rd_value});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[7] = 32'h1234_5678;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      pre_en = 1'b1; pre_addr = AW'(i); pre_data = ref_mem[i];
    end
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [W-1:0] d);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_wdata = d;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_accept", bus.cmd_ready, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input bit rnd, output logic [AW-1:0] a, output logic [W-1:0] d,
                         output logic l);
    int n = 0;
    bit seen = 0;
    bit done = 0;
    logic [AW-1:0] ha = '0;
    logic [W-1:0]  hd = '0;
    logic          hl = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) begin
        // While stalled, the offered response must not move.
        if (seen) begin
          check("rsp_stable_addr", bus.rsp_addr, ha);
          check("rsp_stable_data", bus.rsp_data, hd);
          check("rsp_stable_last", bus.rsp_last, hl);
        end
        seen = 1; ha = bus.rsp_addr; hd = bus.rsp_data; hl = bus.rsp_last;
        bus.rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.rsp_ready) begin
          @(posedge clk);
          #1 bus.rsp_ready = 1'b0;
          done = 1;
        end
      end
    end
    check("rsp_arrived", done, 1);
    a = ha; d = hd; l = hl;
  endtask

  task automatic dump_check();
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic          l;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ref_mem[i]);
    drive_cmd(2'b10, AW'($urandom_range(0, DEPTH - 1)), $urandom);
    for (int i = 0; i < DEPTH; i++) begin
      get_rsp(1, a, d, l);
      check("dump_addr", a, i);
      check("dump_data", d, exp_q.pop_front());
      check("dump_last", l, (i == DEPTH - 1));
    end
    @(negedge clk);
    check("dump_done_busy", busy, 0);
    check("dump_done_rsp_valid", bus.rsp_valid, 0);
    check("dump_no_writes", wr_q.size(), 0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic          l;
    logic [W-1:0]  wd;
    int            first;
    int            n;
    wr_t           e;

    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset phase, with the register file preloaded while the controller is held.
    preload();
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_last", bus.rsp_last, 0);
    check("rst_rsp_addr", bus.rsp_addr, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_rd_addr", bus.rf_rd_addr, 0);
    check("rst_rf_rd_value", bus.rf_rd_value, 0);
    check("rst_rf_rs1_addr", bus.rf_rs1_addr, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", bus.cmd_ready, 1);
    check("idle_busy", busy, 0);

    // Single write.
    drive_cmd(2'b01, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    check("wr_rf_we", bus.rf_we, 1);
    check("wr_rf_rd_addr", bus.rf_rd_addr, 5);
    check("wr_rf_rd_value", bus.rf_rd_value, 32'hDEAD_BEEF);
    check("wr_rsp_valid_early", bus.rsp_valid, 0);
    get_rsp(0, a, d, l);
    check("wr_rsp_addr", a, 5);
    check("wr_rsp_data", d, 32'hDEAD_BEEF);
    check("wr_rsp_last", l, 1);
    check("wr_pulse_count", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      e = wr_q.pop_front();
      check("wr_log_addr", e.a, 5);
      check("wr_log_data", e.d, 32'hDEAD_BEEF);
    end
    ref_mem[5] = 32'hDEAD_BEEF;

    // Single read: READ cycle, then the response in the second cycle after accept.
    drive_cmd(2'b00, 5'd7, $urandom);
    @(negedge clk);
    check("rd_rsp_valid_cycle1", bus.rsp_valid, 0);
    check("rd_rs1_addr", bus.rf_rs1_addr, 7);
    check("rd_busy", busy, 1);
    check("rd_rf_we", bus.rf_we, 0);
    @(negedge clk);
    check("rd_rsp_valid_cycle2", bus.rsp_valid, 1);
    get_rsp(0, a, d, l);
    check("rd_rsp_addr", a, 7);
    check("rd_rsp_data", d, 32'h1234_5678);
    check("rd_rsp_last", l, 1);

    // Dump with a randomly stalling consumer.
    dump_check();

    // Clear-all.
    drive_cmd(2'b11, AW'($urandom), $urandom);
    get_rsp(0, a, d, l);
    check("clr_rsp_addr", a, 0);
    check("clr_rsp_data", d, 0);
    check("clr_rsp_last", l, 1);
    check("clr_pulse_count", wr_q.size(), DEPTH - 1);
    first = (wr_q.size() > 0) ? wr_q[0].cyc : 0;
    for (int i = 0; i < DEPTH - 1 && wr_q.size() > 0; i++) begin
      e = wr_q.pop_front();
      check("clr_addr", e.a, i + 1);
      check("clr_data", e.d, 0);
      check("clr_consecutive", e.cyc, first + i);
    end
    for (int i = 1; i < DEPTH; i++) ref_mem[i] = '0;

    // Write to register 0 is dropped.
    drive_cmd(2'b01, 5'd0, 32'hA5A5_0001 | $urandom);
    get_rsp(0, a, d, l);
    check("wr0_rsp_addr", a, 0);
    check("wr0_rsp_data", d, 0);
    check("wr0_rsp_last", l, 1);
    check("wr0_no_pulse", wr_q.size(), 0);

    // Random reads and writes against the reference contents.
    for (int k = 0; k < 24; k++) begin
      a  = AW'($urandom_range(0, DEPTH - 1));
      wd = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        drive_cmd(2'b01, a, wd);
        n = a;
        get_rsp(1, a, d, l);
        check("rnd_wr_rsp_addr", a, n);
        check("rnd_wr_rsp_data", d, (n == 0) ? '0 : wd);
        check("rnd_wr_rsp_last", l, 1);
        check("rnd_wr_pulses", wr_q.size(), (n == 0) ? 0 : 1);
        while (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          check("rnd_wr_log_addr", e.a, n);
          check("rnd_wr_log_data", e.d, wd);
        end
        if (n != 0) ref_mem[n] = wd;
      end else begin
        drive_cmd(2'b00, a, wd);
        n = a;
        get_rsp(1, a, d, l);
        check("rnd_rd_rsp_addr", a, n);
        check("rnd_rd_rsp_data", d, ref_mem[n]);
        check("rnd_rd_rsp_last", l, 1);
      end
    end

    // Reset while clearing register 10 aborts the clear.
    preload();
    drive_cmd(2'b11, '0, '0);
    n = 0;
    do begin
      @(negedge clk);
      #1 n++;
    end while (!(bus.rf_we && bus.rf_rd_addr == 5'd10) && n < 100);
    check("abort_found_addr10", bus.rf_rd_addr, 10);
    rst = 1'b0;
    #1;
    check("abort_rf_we", bus.rf_we, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp", bus.rsp_valid, 0);
    end
    check("abort_pulse_count", wr_q.size(), 10);
    for (int i = 1; i <= 10 && wr_q.size() > 0; i++) begin
      e = wr_q.pop_front();
      check("abort_log_addr", e.a, i);
    end
    for (int i = 1; i < 10; i++) ref_mem[i] = '0;
    dump_check();

    // cmd_valid held high while busy: the second command waits for IDLE.
    wd = $urandom;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_addr = 5'd3; bus.cmd_wdata = wd;
    check("hold_first_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1 bus.cmd_op = 2'b00;
    bus.cmd_wdata = ~wd;
    @(negedge clk);
    check("hold_wr_ready", bus.cmd_ready, 0);
    check("hold_wr_we", bus.rf_we, 1);
    repeat (3) begin
      @(negedge clk);
      check("hold_resp_ready", bus.cmd_ready, 0);
      check("hold_resp_busy", busy, 1);
      check("hold_resp_valid", bus.rsp_valid, 1);
      check("hold_resp_data", bus.rsp_data, wd);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("hold_idle_ready", bus.cmd_ready, 1);
    check("hold_idle_busy", busy, 0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    get_rsp(0, a, d, l);
    check("hold_rd_addr", a, 3);
    check("hold_rd_data", d, wd);
    check("hold_rd_last", l, 1);
    check("hold_pulse_count", wr_q.size(), 1);
    while (wr_q.size() > 0) void'(wr_q.pop_front());
    @(negedge clk);
    check("hold_end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
